pulse_duty_meter: RTL and testbench

- Measurement block that works in the opposite direction to the square/pulse generator. The generator turns a phase and duty setting into a pulse; this block takes a pulse and recovers its period, high time, duty cycle and nearest fixed duty class.
- Sits on the analysis/loopback path. It is fed either by the generator's 12-bit full-scale pulse output or by an external sampled square signal.
- Results go to the display and control logic, which use them for self-test and auto-configuration.

---
 rtl/pulse_duty_meter.sv | 238 +++++++++++++++++++++++
 tb/tb_pulse_duty_meter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_duty_meter.sv
// pulse_duty_meter
//   Recovers period, high time, duty cycle and nearest fixed duty class from
//   a sampled pulse train. The pulse is taken as high when sample_in[11] is
//   set. Each period is measured rising edge to rising edge. A 7-step
//   restoring divide then produces the duty percentage.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   sample_in    12-bit sampled pulse level (high when bit 11 = 1)
//   period       last measured period in clk cycles
//   high_time    high cycles within that period
//   duty_pct     floor(high_time*100/period), 0..100
//   duty_class   nearest duty: 00=1/2, 01=1/3, 10=1/4, 11=1/7
//   class_match  duty_pct is within TOL_PCT of the class target
//   meas_valid   one-cycle strobe when new results are presented
//   no_signal    no rising edge seen for TIMEOUT cycles
module pulse_duty_meter #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 10000000,
    parameter int TOL_PCT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      sample_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic [1:0]       duty_class,
    output logic             class_match,
    output logic             meas_valid,
    output logic             no_signal
);

    localparam int NUM_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [6:0]       TOL_C     = 7'(TOL_PCT);

    typedef enum logic [1:0] {IDLE, ARM, DIV, CLASS} state_t;

    // Only the MSB carries the logic level.
    logic sample_unused;
    assign sample_unused = ^sample_in[10:0];

    state_t           state_q, state_d;
    logic             s0_q, s0_d, s1_q, s1_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [6:0]       quo_q, quo_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [6:0]       duty_q, duty_d;
    logic [1:0]       class_q, class_d;
    logic             match_q, match_d;
    logic             valid_q, valid_d;
    logic             nosig_q, nosig_d;

    logic             rise;
    logic             timeout_hit;
    logic [NUM_W-1:0] div_trial;
    logic [NUM_W-1:0] h_ext;
    logic [1:0]       cls;
    logic [6:0]       cls_tgt;
    logic             cls_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [6:0] abs_dist(input logic [6:0] a, input logic [6:0] b);
        logic signed [7:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < 0) ? 7'(-diff) : 7'(diff);
    endfunction

    assign rise = s0_q & ~s1_q;

    // A rise in the same cycle wins over the timeout.
    assign timeout_hit = ~rise && (period_cnt_q >= TIMEOUT_C) &&
                         ((state_q == IDLE) || (state_q == ARM));

    assign h_ext     = NUM_W'(high_cnt_q);
    assign div_trial = NUM_W'(p_q) << bit_q;

    // Decision points sit at the midpoints between targets. q=29 is an
    // exact tie between 33 and 25, and the lower code wins.
    always_comb begin
        if (quo_q >= 7'd42) begin
            cls     = 2'b00;
            cls_tgt = 7'd50;
        end else if (quo_q >= 7'd29) begin
            cls     = 2'b01;
            cls_tgt = 7'd33;
        end else if (quo_q >= 7'd20) begin
            cls     = 2'b10;
            cls_tgt = 7'd25;
        end else begin
            cls     = 2'b11;
            cls_tgt = 7'd14;
        end
        cls_match = (abs_dist(quo_q, cls_tgt) <= TOL_C);
    end

    always_comb begin
        state_d      = state_q;
        s0_d         = sample_in[11];
        s1_d         = s0_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        p_d          = p_q;
        h_d          = h_q;
        num_d        = num_q;
        quo_d        = quo_q;
        bit_d        = bit_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        duty_d       = duty_q;
        class_d      = class_q;
        match_d      = match_q;
        valid_d      = 1'b0;
        nosig_d      = nosig_q;

        // The counters keep running in every state, so rises that land
        // during DIV/CLASS still restart the next period correctly.
        if (rise) begin
            period_cnt_d = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
        end else begin
            period_cnt_d = sat_inc(period_cnt_q);
            if (s0_q) begin
                high_cnt_d = sat_inc(high_cnt_q);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    p_d     = period_cnt_q;
                    h_d     = high_cnt_q;
                    num_d   = (h_ext << 6) + (h_ext << 5) + (h_ext << 2);
                    quo_d   = 7'd0;
                    bit_d   = 3'd6;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (num_q >= div_trial) begin
                    num_d        = num_q - div_trial;
                    quo_d[bit_q] = 1'b1;
                end
                if (bit_q == 3'd0) begin
                    state_d = CLASS;
                end else begin
                    bit_d = bit_q - 3'd1;
                end
            end
            CLASS: begin
                period_d    = p_q;
                high_time_d = h_q;
                duty_d      = quo_q;
                class_d     = cls;
                match_d     = cls_match;
                valid_d     = 1'b1;
                nosig_d     = 1'b0;
                state_d     = ARM;
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            nosig_d     = 1'b1;
            period_d    = '0;
            high_time_d = '0;
            duty_d      = '0;
            class_d     = '0;
            match_d     = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            p_q          <= '0;
            h_q          <= '0;
            num_q        <= '0;
            quo_q        <= '0;
            bit_q        <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            duty_q       <= '0;
            class_q      <= '0;
            match_q      <= 1'b0;
            valid_q      <= 1'b0;
            nosig_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            p_q          <= p_d;
            h_q          <= h_d;
            num_q        <= num_d;
            quo_q        <= quo_d;
            bit_q        <= bit_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            duty_q       <= duty_d;
            class_q      <= class_d;
            match_q      <= match_d;
            valid_q      <= valid_d;
            nosig_q      <= nosig_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign duty_pct    = duty_q;
    assign duty_class  = class_q;
    assign class_match = match_q;
    assign meas_valid  = valid_q;
    assign no_signal   = nosig_q;

endmodule

// File: tb/tb_pulse_duty_meter.sv
// tb_pulse_duty_meter
//   Drives pulse trains, timeouts and resets into pulse_duty_meter. A
//   reference model works on rise-to-rise intervals and plain division and
//   queues the expected strobes. A separate monitor checks every strobe and
//   the no_signal flag.
module tb_pulse_duty_meter;

    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 1000;
    localparam int TOL_PCT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [11:0]      sample_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [6:0]       duty_pct;
    logic [1:0]       duty_class;
    logic             class_match;
    logic             meas_valid;
    logic             no_signal;

    pulse_duty_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TOL_PCT (TOL_PCT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .period      (period),
        .high_time   (high_time),
        .duty_pct    (duty_pct),
        .duty_class  (duty_class),
        .class_match (class_match),
        .meas_valid  (meas_valid),
        .no_signal   (no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int p;
        int h;
        int d;
        int cls;
        bit mt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   exp_ns_cur = 1'b0;
    bit   exp_ns_next = 1'b0;

    // Reference model state: what the meter is doing in terms of the
    // pulse train, not its internal encoding.
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_BUSY = 2;
    int mode     = M_IDLE;
    int anchor   = 0;     // cycle from which the current interval counts
    int hcount   = 0;     // high cycles seen since anchor
    int busy_end = 0;     // first cycle a new capture is possible again
    int cap_cyc  = -100;
    bit s0_c = 1'b0, s1_c = 1'b0;
    bit last_rst = 1'b0;
    bit rst_div3 = 1'b0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Nearest of the four target duties; ties go to the lower code.
    function automatic void nearest(input int q, output int cls, output bit mt);
        int tg[4];
        int best;
        tg[0] = 50; tg[1] = 33; tg[2] = 25; tg[3] = 14;
        best = 0;
        for (int i = 1; i < 4; i++) begin
            if (iabs(q - tg[i]) < iabs(q - tg[best])) best = i;
        end
        cls = best;
        mt  = (iabs(q - tg[best]) <= TOL_PCT);
    endfunction

    task automatic check_reset_state();
        n_cmp++;
        if (period !== '0 || high_time !== '0 || duty_pct !== '0 || duty_class !== '0 ||
            class_match !== 1'b0 || meas_valid !== 1'b0 || no_signal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state cyc=%0d got p=%0d h=%0d d=%0d c=%0d m=%0b v=%0b ns=%0b want all 0",
                     cyc, period, high_time, duty_pct, duty_class, class_match, meas_valid, no_signal);
        end
    endtask

    task automatic tick(input bit b, input bit r_in);
        int   m;
        int   p;
        bit   r;
        bit   rise;
        exp_t e;
        @(posedge clk);
        #1;
        m = cyc;
        exp_ns_cur = exp_ns_next;
        if (last_rst) check_reset_state();

        r = r_in || (rst_div3 && mode == M_BUSY && m == cap_cyc + 3);
        if (r && !r_in) rst_div3 = 1'b0;

        rst = r;
        if ($urandom_range(0, 3) == 0)
            sample_in = b ? 12'd2048 : 12'd2047;
        else
            sample_in = b ? 12'($urandom_range(2048, 4095)) : 12'($urandom_range(0, 2047));

        rise = s0_c && !s1_c;
        p    = m - anchor;
        if (mode == M_BUSY && m == busy_end - 1) exp_ns_next = 1'b0;
        if (mode == M_BUSY && m >= busy_end) mode = M_ARM;
        if (rise) begin
            if (mode == M_IDLE) begin
                mode = M_ARM;
            end else if (mode == M_ARM) begin
                e.cyc = m + 9;
                e.p   = p;
                e.h   = hcount;
                e.d   = (hcount * 100) / p;
                nearest(e.d, e.cls, e.mt);
                sbq.push_back(e);
                mode     = M_BUSY;
                cap_cyc  = m;
                busy_end = m + 9;
            end
            anchor = m;
            hcount = 1;
        end else begin
            if (mode != M_BUSY && p >= TIMEOUT) begin
                mode        = M_IDLE;
                exp_ns_next = 1'b1;
            end
            hcount += int'(s0_c);
        end

        if (r) begin
            mode        = M_IDLE;
            anchor      = m + 1;
            hcount      = 0;
            exp_ns_next = 1'b0;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc > m) sbq.delete(i);
            end
            s0_c = 1'b0;
            s1_c = 1'b0;
        end else begin
            s1_c = s0_c;
            s0_c = b;
        end
        last_rst = r;
    endtask

    task automatic pulses(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < per; j++) tick(j < hi, 1'b0);
        end
    endtask

    task automatic hold(input bit v, input int n);
        for (int j = 0; j < n; j++) tick(v, 1'b0);
    endtask

    // Monitor: checks no_signal every cycle and each strobe against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_cmp++;
                if (no_signal !== exp_ns_cur) begin
                    n_err++;
                    $display("FAIL no_signal cyc=%0d got=%0b want=%0b", cyc, no_signal, exp_ns_cur);
                end
                if (exp_ns_cur) begin
                    n_cmp++;
                    if (period !== '0 || high_time !== '0 || duty_pct !== '0 ||
                        duty_class !== '0 || class_match !== 1'b0) begin
                        n_err++;
                        $display("FAIL timeout_zero cyc=%0d got p=%0d h=%0d d=%0d c=%0d m=%0b want all 0",
                                 cyc, period, high_time, duty_pct, duty_class, class_match);
                    end
                end
                if (meas_valid === 1'b1) begin
                    n_cmp++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_strobe cyc=%0d got p=%0d h=%0d d=%0d want none",
                                 cyc, period, high_time, duty_pct);
                    end else begin
                        e = sbq.pop_front();
                        if (e.cyc != cyc || period !== CNT_W'(e.p) || high_time !== CNT_W'(e.h) ||
                            duty_pct !== 7'(e.d) || duty_class !== 2'(e.cls) || class_match !== e.mt) begin
                            n_err++;
                            $display("FAIL strobe cyc=%0d got p=%0d h=%0d d=%0d c=%0d m=%0b want cyc=%0d p=%0d h=%0d d=%0d c=%0d m=%0b",
                                     cyc, period, high_time, duty_pct, duty_class, class_match,
                                     e.cyc, e.p, e.h, e.d, e.cls, e.mt);
                        end
                    end
                end else if (meas_valid !== 1'b0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL meas_valid_x cyc=%0d got=%b want 0/1", cyc, meas_valid);
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    e = sbq.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_strobe cyc=%0d got none want p=%0d h=%0d d=%0d at cyc=%0d",
                             cyc, e.p, e.h, e.d, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int per;
        int hi;
        rst       = 1'b1;
        sample_in = 12'd0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        mon_en = 1'b1;

        pulses(100, 50, 4);                           // 50% -> class 00, match
        pulses(70, 10, 4);                            // 14% -> class 11, match
        pulses(300, 100, 3);                          // 33% -> class 01, match
        pulses(100, 37, 4);                           // 37% -> class 01, no match
        pulses(100, 29, 4);                           // tie -> class 01, no match
        pulses(100, 50, 3);
        hold(1'b0, 1200);                             // constant low timeout
        pulses(100, 50, 4);                           // recovery
        hold(1'b1, 1200);                             // constant high timeout
        pulses(100, 50, 4);
        pulses(5, 2, 20);                             // short period, every 2nd rise
        rst_div3 = 1'b1;
        pulses(100, 50, 4);                           // reset lands in DIV
        pulses(100, 50, 3);

        for (int s = 0; s < 20; s++) begin
            per = int'($urandom_range(2, 400));
            hi  = int'($urandom_range(1, per - 1));
            pulses(per, hi, int'($urandom_range(2, 4)));
        end
        hold(1'b0, 30);

        n_cmp++;
        if (sbq.size() != 0 || rst_div3) begin
            n_err++;
            $display("FAIL drain got pending=%0d rst_fired=%0b want pending=0 rst_fired=1",
                     sbq.size(), !rst_div3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
